// File: rtl/multicycle_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : multicycle_controller                                      |
// | Description : Main control FSM of the multicycle MIPS datapath.          |
// |               Steps the shared ALU, memory port, IR, PC and register     |
// |               file through several cycles per instruction (LW, SW,       |
// |               R-type, BEQ, ADDI, J), waits on the memory-ready           |
// |               handshake and counts retired instructions.                 |
// | Ports       : CLK, RESET_N (sync, active-low)                            |
// |               Op[5:0], Zero, MemReady           - status inputs          |
// |               IorD, IRWrite, MemWrite, RegDst, MemtoReg, RegWrite,       |
// |               ALUSrcA, ALUSrcB[1:0], ALUOp[1:0], PCSrc[1:0], PCEn        |
// |                                                 - datapath controls      |
// |               Illegal                           - unknown opcode         |
// |               State[3:0]                        - current state (debug)  |
// |               InstrCount[COUNT_WIDTH-1:0]       - retired instructions   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module multicycle_controller #(
   parameter int COUNT_WIDTH  = 32,
   parameter bit ILLEGAL_HALT = 1'b0
) (
   input  logic                   CLK,
   input  logic                   RESET_N,
   input  logic [5:0]             Op,
   input  logic                   Zero,
   input  logic                   MemReady,
   output logic                   IorD,
   output logic                   IRWrite,
   output logic                   MemWrite,
   output logic                   RegDst,
   output logic                   MemtoReg,
   output logic                   RegWrite,
   output logic                   ALUSrcA,
   output logic [1:0]             ALUSrcB,
   output logic [1:0]             ALUOp,
   output logic [1:0]             PCSrc,
   output logic                   PCEn,
   output logic                   Illegal,
   output logic [3:0]             State,
   output logic [COUNT_WIDTH-1:0] InstrCount
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECUTE  = 4'd6,
      ALUWB    = 4'd7,
      BRANCH   = 4'd8,
      ADDIEX   = 4'd9,
      ADDIWB   = 4'd10,
      JUMP     = 4'd11,
      ILLEGAL  = 4'd12
   } state_t;

   localparam logic [5:0] c_op_lw    = 6'b100011;
   localparam logic [5:0] c_op_sw    = 6'b101011;
   localparam logic [5:0] c_op_rtype = 6'b000000;
   localparam logic [5:0] c_op_beq   = 6'b000100;
   localparam logic [5:0] c_op_addi  = 6'b001000;
   localparam logic [5:0] c_op_j     = 6'b000010;

   state_t                 r_state;
   state_t                 w_next;
   logic [COUNT_WIDTH-1:0] r_count;
   logic                   w_retire;
   logic                   w_irwrite;
   logic                   w_memwrite;
   logic                   w_regwrite;
   logic                   w_pcen;

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         r_state <= FETCH;
         r_count <= '0;
      end else begin
         r_state <= w_next;
         if (w_retire) begin
            r_count <= r_count + COUNT_WIDTH'(1);
         end
      end
   end

   always_comb begin
      w_next     = FETCH;
      w_retire   = 1'b0;
      w_irwrite  = 1'b0;
      w_memwrite = 1'b0;
      w_regwrite = 1'b0;
      w_pcen     = 1'b0;
      IorD       = 1'b0;
      RegDst     = 1'b0;
      MemtoReg   = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      ALUOp      = 2'b00;
      PCSrc      = 2'b00;
      Illegal    = 1'b0;

      case (r_state)
         FETCH: begin
            ALUSrcB = 2'b01;
            if (MemReady) begin
               w_irwrite = 1'b1;
               w_pcen    = 1'b1;
               w_next    = DECODE;
            end else begin
               w_next    = FETCH;
            end
         end
         DECODE: begin
            // Precompute the branch target into ALUOut while Op is decoded.
            ALUSrcB = 2'b11;
            case (Op)
               c_op_lw, c_op_sw: w_next = MEMADR;
               c_op_rtype:       w_next = EXECUTE;
               c_op_beq:         w_next = BRANCH;
               c_op_addi:        w_next = ADDIEX;
               c_op_j:           w_next = JUMP;
               default:          w_next = ILLEGAL;
            endcase
         end
         MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            w_next  = (Op == c_op_lw) ? MEMREAD : MEMWRITE;
         end
         MEMREAD: begin
            IorD   = 1'b1;
            w_next = MemReady ? MEMWB : MEMREAD;
         end
         MEMWB: begin
            MemtoReg   = 1'b1;
            w_regwrite = 1'b1;
            w_retire   = 1'b1;
            w_next     = FETCH;
         end
         MEMWRITE: begin
            // The write strobe stays up until memory accepts it.
            IorD       = 1'b1;
            w_memwrite = 1'b1;
            if (MemReady) begin
               w_retire = 1'b1;
               w_next   = FETCH;
            end else begin
               w_next   = MEMWRITE;
            end
         end
         EXECUTE: begin
            ALUSrcA = 1'b1;
            ALUOp   = 2'b10;
            w_next  = ALUWB;
         end
         ALUWB: begin
            RegDst     = 1'b1;
            w_regwrite = 1'b1;
            w_retire   = 1'b1;
            w_next     = FETCH;
         end
         BRANCH: begin
            ALUSrcA  = 1'b1;
            ALUOp    = 2'b01;
            PCSrc    = 2'b01;
            w_pcen   = Zero;
            w_retire = 1'b1;
            w_next   = FETCH;
         end
         ADDIEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            w_next  = ADDIWB;
         end
         ADDIWB: begin
            w_regwrite = 1'b1;
            w_retire   = 1'b1;
            w_next     = FETCH;
         end
         JUMP: begin
            PCSrc    = 2'b10;
            w_pcen   = 1'b1;
            w_retire = 1'b1;
            w_next   = FETCH;
         end
         ILLEGAL: begin
            Illegal = 1'b1;
            w_next  = ILLEGAL_HALT ? ILLEGAL : FETCH;
         end
         // Unused codes recover to FETCH with every output low.
         default: w_next = FETCH;
      endcase
   end

   // Architectural write strobes are suppressed while reset is asserted so
   // an abandoned instruction cannot commit anything.
   assign IRWrite    = w_irwrite  & RESET_N;
   assign MemWrite   = w_memwrite & RESET_N;
   assign RegWrite   = w_regwrite & RESET_N;
   assign PCEn       = w_pcen     & RESET_N;
   assign State      = r_state;
   assign InstrCount = r_count;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_multicycle_controller                                   |
// | Description : Bench for multicycle_controller. Three instances share     |
// |               stimulus: default, ILLEGAL_HALT=1, and COUNT_WIDTH=2.      |
// |               An instruction-level model expands each instruction into   |
// |               its expected cycle list; a compare process checks every    |
// |               cycle, and literal checks pin the model.                   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_multicycle_controller;

   localparam int S_F = 0, S_D = 1, S_MA = 2, S_MR = 3, S_MWB = 4, S_MW = 5;
   localparam int S_EX = 6, S_AW = 7, S_BR = 8, S_AE = 9, S_AWB = 10;
   localparam int S_J = 11, S_IL = 12;

   localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011;
   localparam logic [5:0] OP_R = 6'b000000, OP_BEQ = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000, OP_J = 6'b000010;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] op;
   logic       zero;
   logic       mr;

   logic       iord[3], irw[3], mw[3], rdst[3], m2r[3], rw[3], srca[3];
   logic [1:0] srcb[3], aluop[3], pcsrc[3];
   logic       pcen[3], ill[3];
   logic [3:0] st[3];
   logic [31:0] cnt0;
   logic [31:0] cnth;
   logic [1:0]  cntw;

   always #5 clk = ~clk;

   multicycle_controller u_dut0 (
      .CLK(clk), .RESET_N(rst_n), .Op(op), .Zero(zero), .MemReady(mr),
      .IorD(iord[0]), .IRWrite(irw[0]), .MemWrite(mw[0]), .RegDst(rdst[0]),
      .MemtoReg(m2r[0]), .RegWrite(rw[0]), .ALUSrcA(srca[0]),
      .ALUSrcB(srcb[0]), .ALUOp(aluop[0]), .PCSrc(pcsrc[0]), .PCEn(pcen[0]),
      .Illegal(ill[0]), .State(st[0]), .InstrCount(cnt0));

   multicycle_controller #(.COUNT_WIDTH(32), .ILLEGAL_HALT(1'b1)) u_duth (
      .CLK(clk), .RESET_N(rst_n), .Op(op), .Zero(zero), .MemReady(mr),
      .IorD(iord[1]), .IRWrite(irw[1]), .MemWrite(mw[1]), .RegDst(rdst[1]),
      .MemtoReg(m2r[1]), .RegWrite(rw[1]), .ALUSrcA(srca[1]),
      .ALUSrcB(srcb[1]), .ALUOp(aluop[1]), .PCSrc(pcsrc[1]), .PCEn(pcen[1]),
      .Illegal(ill[1]), .State(st[1]), .InstrCount(cnth));

   multicycle_controller #(.COUNT_WIDTH(2), .ILLEGAL_HALT(1'b0)) u_dutw (
      .CLK(clk), .RESET_N(rst_n), .Op(op), .Zero(zero), .MemReady(mr),
      .IorD(iord[2]), .IRWrite(irw[2]), .MemWrite(mw[2]), .RegDst(rdst[2]),
      .MemtoReg(m2r[2]), .RegWrite(rw[2]), .ALUSrcA(srca[2]),
      .ALUSrcB(srcb[2]), .ALUOp(aluop[2]), .PCSrc(pcsrc[2]), .PCEn(pcen[2]),
      .Illegal(ill[2]), .State(st[2]), .InstrCount(cntw));

   // Control word: {IorD,IRWrite,MemWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,
   //                ALUSrcB[1:0],ALUOp[1:0],PCSrc[1:0],PCEn,Illegal}
   typedef struct {
      logic        rst_n;
      logic [5:0]  op;
      logic        zero;
      logic        mr;
      logic [3:0]  st;
      logic [14:0] ctl;
      logic        retire;
   } rec_t;

   rec_t        q[$];
   rec_t        cur;
   bit          cur_valid = 1'b0;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_cnt = 32'd0;
   logic [31:0] exp_cnth = 32'd0;
   bit          halted = 1'b0;

   function automatic logic [14:0] pk(logic a_iord, logic a_irw, logic a_mw,
         logic a_rdst, logic a_m2r, logic a_rw, logic a_srca, logic [1:0] a_srcb,
         logic [1:0] a_aluop, logic [1:0] a_pcsrc, logic a_pcen, logic a_ill);
      return {a_iord, a_irw, a_mw, a_rdst, a_m2r, a_rw, a_srca,
              a_srcb, a_aluop, a_pcsrc, a_pcen, a_ill};
   endfunction

   // Control table of each step of an instruction, straight from the rules.
   function automatic logic [14:0] ctl_of(int s, logic m, logic z);
      case (s)
         S_F:   return pk(0, m, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, m, 0);
         S_D:   return pk(0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0, 0);
         S_MA:  return pk(0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0, 0);
         S_MR:  return pk(1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
         S_MWB: return pk(0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0);
         S_MW:  return pk(1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
         S_EX:  return pk(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00, 0, 0);
         S_AW:  return pk(0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0);
         S_BR:  return pk(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, z, 0);
         S_AE:  return pk(0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0, 0);
         S_AWB: return pk(0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0);
         S_J:   return pk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 1, 0);
         S_IL:  return pk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1);
         default: return 15'd0;
      endcase
   endfunction

   function automatic void add(int s, logic [5:0] o, logic z, logic m,
                               logic ret, logic rn = 1'b1);
      rec_t r;
      r.rst_n  = rn;
      r.op     = o;
      r.zero   = z;
      r.mr     = m;
      r.st     = 4'(s);
      r.ctl    = ctl_of(s, m, z);
      r.retire = ret;
      if (!rn) begin
         r.ctl[13] = 1'b0;   // IRWrite
         r.ctl[12] = 1'b0;   // MemWrite
         r.ctl[9]  = 1'b0;   // RegWrite
         r.ctl[1]  = 1'b0;   // PCEn
      end
      q.push_back(r);
   endfunction

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic [5:0] r6();
      return 6'($urandom_range(0, 63));
   endfunction

   // Expand one instruction into its cycle list. fw = fetch stall cycles,
   // mwt = memory stall cycles in MEMREAD/MEMWRITE.
   function automatic void push_instr(logic [5:0] o, logic z, int fw, int mwt);
      for (int i = 0; i < fw; i++) add(S_F, r6(), rb(), 1'b0, 1'b0);
      add(S_F, r6(), rb(), 1'b1, 1'b0);
      add(S_D, o, rb(), rb(), 1'b0);
      case (o)
         OP_LW: begin
            add(S_MA, o, rb(), rb(), 1'b0);
            for (int i = 0; i < mwt; i++) add(S_MR, o, rb(), 1'b0, 1'b0);
            add(S_MR, o, rb(), 1'b1, 1'b0);
            add(S_MWB, o, rb(), rb(), 1'b1);
         end
         OP_SW: begin
            add(S_MA, o, rb(), rb(), 1'b0);
            for (int i = 0; i < mwt; i++) add(S_MW, o, rb(), 1'b0, 1'b0);
            add(S_MW, o, rb(), 1'b1, 1'b1);
         end
         OP_R: begin
            add(S_EX, o, rb(), rb(), 1'b0);
            add(S_AW, o, rb(), rb(), 1'b1);
         end
         OP_BEQ:  add(S_BR, o, z, rb(), 1'b1);
         OP_ADDI: begin
            add(S_AE, o, rb(), rb(), 1'b0);
            add(S_AWB, o, rb(), rb(), 1'b1);
         end
         OP_J:    add(S_J, o, rb(), rb(), 1'b1);
         default: add(S_IL, o, rb(), rb(), 1'b0);
      endcase
   endfunction

   // n reset cycles; the first shows the state the main instance is in.
   function automatic void push_reset(int n, int first);
      add(first, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 1; i < n; i++) add(S_F, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endfunction

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s at %0t: actual %0h required %0h", nm, $time, act, expv);
      end
   endtask

   function automatic logic [14:0] got_ctl(int k);
      return {iord[k], irw[k], mw[k], rdst[k], m2r[k], rw[k], srca[k],
              srcb[k], aluop[k], pcsrc[k], pcen[k], ill[k]};
   endfunction

   task automatic exec_q();
      while (q.size() > 0) begin
         @(posedge clk);
         #1;
         cur = q.pop_front();
         rst_n = cur.rst_n;
         op    = cur.op;
         zero  = cur.zero;
         mr    = cur.mr;
         cur_valid = 1'b1;
      end
   endtask

   // One modelled FETCH stall cycle, then step past the edge so literal
   // checks see the counter update of the previous instruction.
   task automatic idle();
      add(S_F, r6(), 1'b0, 1'b0, 1'b0);
      exec_q();
      #1;
   endtask

   always @(negedge clk) begin
      if (cur_valid) begin
         logic [3:0]  est;
         logic [14:0] ectl;
         for (int k = 0; k < 3; k++) begin
            est  = cur.st;
            ectl = cur.ctl;
            if (k == 1 && halted) begin
               est  = 4'd12;
               ectl = 15'd1;
            end
            check($sformatf("state[%0d]", k), 32'(st[k]), 32'(est));
            check($sformatf("ctl[%0d]", k), 32'(got_ctl(k)), 32'(ectl));
         end
         check("count_main", cnt0, exp_cnt);
         check("count_halt", cnth, exp_cnth);
         check("count_wrap", 32'(cntw), 32'(exp_cnt[1:0]));
         if (!cur.rst_n) begin
            exp_cnt  = 32'd0;
            exp_cnth = 32'd0;
            halted   = 1'b0;
         end else begin
            if (cur.retire) begin
               exp_cnt = exp_cnt + 32'd1;
               if (!halted) exp_cnth = exp_cnth + 32'd1;
            end
            if (cur.st == 4'd12) halted = 1'b1;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1);
   end

   initial begin
      int wexp[5];
      wexp = '{1, 2, 3, 0, 1};
      rst_n = 1'b0;
      op    = 6'd0;
      zero  = 1'b0;
      mr    = 1'b0;

      push_reset(2, S_F);
      idle();
      check("lit_reset_count", cnt0, 32'd0);
      check("lit_reset_state", 32'(st[0]), 32'd0);

      push_instr(OP_R, 1'b0, 0, 0);
      idle();
      check("lit_rtype_count", cnt0, 32'd1);

      push_instr(OP_LW, 1'b0, 0, 3);
      idle();
      check("lit_lw_count", cnt0, 32'd2);

      push_instr(OP_BEQ, 1'b1, 0, 0);
      push_instr(OP_BEQ, 1'b0, 0, 0);
      idle();
      check("lit_beq_count", cnt0, 32'd4);

      push_instr(OP_ADDI, 1'b0, 1, 0);
      push_instr(OP_J, 1'b0, 0, 0);
      push_instr(OP_SW, 1'b0, 2, 2);
      idle();
      check("lit_sw_count", cnt0, 32'd7);

      push_instr(6'b111111, 1'b0, 0, 0);
      idle();
      check("lit_illegal_count", cnt0, 32'd7);
      check("lit_illegal_pulse_done", 32'(ill[0]), 32'd0);
      check("lit_halt_illegal", 32'(ill[1]), 32'd1);
      check("lit_halt_state", 32'(st[1]), 32'd12);

      push_instr(6'b000011, 1'b0, 0, 0);
      push_instr(OP_R, 1'b0, 0, 0);
      idle();
      check("lit_after_illegal_count", cnt0, 32'd8);
      check("lit_halt_count_frozen", cnth, 32'd7);

      push_reset(2, S_F);
      idle();
      check("lit_halt_released", 32'(ill[1]), 32'd0);
      check("lit_halt_count_reset", cnth, 32'd0);

      // Reset while a store is still waiting on memory.
      push_instr(OP_SW, 1'b0, 0, 2);
      void'(q.pop_back());
      push_reset(2, S_MW);
      idle();
      check("lit_abort_count", cnt0, 32'd0);
      check("lit_abort_state", 32'(st[0]), 32'd0);

      for (int i = 0; i < 5; i++) begin
         push_instr(OP_J, 1'b0, 0, 0);
         idle();
         check($sformatf("lit_wrap_%0d", i), 32'(cntw), 32'(wexp[i]));
      end

      @(negedge clk);
      #1;
      cur_valid = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
